// File: rtl/video_pkg.sv
// Shared constants and types for the IIgs video interrupt generator.
package video_pkg;

  localparam int IRQ_VBL   = 32'd0;
  localparam int IRQ_QTR   = 32'd1;
  localparam int IRQ_SEC   = 32'd2;
  localparam int IRQ_SCAN  = 32'd3;
  localparam int IRQ_CMP0  = 32'd4;

  localparam int N_CMP_DEF = 32'd2;
  localparam int NSRC_DEF  = IRQ_CMP0 + N_CMP_DEF;

  typedef logic [NSRC_DEF-1:0] irq_vec_t;

endpackage

// File: rtl/video_frame_div.sv
// Free-running VBL divider: wrap is asserted on the tick that completes DIV ticks.
module video_frame_div
  import video_pkg::*;
#(
  parameter int DIV = 32'd15
) (
  input  logic clk_vid,
  input  logic reset_n,
  input  logic tick,
  output logic wrap
);

  localparam int            CW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] cnt_r;

  assign wrap = tick & (cnt_r == LAST);

  // tick counter, returns to zero on the same edge that reports wrap
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= wrap ? '0 : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/video_irq_gen.sv
// Multi-source video interrupt controller: VBL, frame-derived ticks, SCB line and raster compares,
// each with sticky status, enable and write-1-to-clear, plus the legacy VBL/scanline pulses.
module video_irq_gen
  import video_pkg::*;
#(
  parameter int H_BITS     = 32'd10,
  parameter int V_BITS     = 32'd9,
  parameter int VBL_LINE   = 32'd400,
  parameter int LINE_H     = 32'd0,
  parameter int SCAN_H     = 32'd640,
  parameter int QTR_FRAMES = 32'd15,
  parameter int SEC_FRAMES = 32'd60,
  parameter int N_CMP      = 32'd2,
  localparam int NSRC      = IRQ_CMP0 + N_CMP
) (
  input  logic                    clk_vid,
  input  logic                    reset_n,
  input  logic [H_BITS-1:0]       H,
  input  logic [V_BITS-1:0]       V,
  input  logic                    shrg_mode,
  input  logic                    scb_irq,
  input  logic [N_CMP*V_BITS-1:0] cmp_line,
  input  logic [NSRC-1:0]         irq_en,
  input  logic [NSRC-1:0]         irq_clr,
  output logic [NSRC-1:0]         irq_status,
  output logic                    irq,
  output logic                    vbl_irq,
  output logic                    scanline_irq,
  output logic                    in_vbl
);

  logic             hpos_line_r;
  logic             hpos_scan_r;
  logic             h_line_s;
  logic             h_scan_s;
  logic             line_start_s;
  logic             scan_pt_s;
  logic             vbl_s;
  logic             qtr_s;
  logic             sec_s;
  logic             scan_s;
  logic [N_CMP-1:0] cmp_s;
  logic [NSRC-1:0]  event_s;
  logic [NSRC-1:0]  status_r;
  logic             vbl_irq_r;
  logic             scanline_irq_r;
  logic             in_vbl_r;

  // Events fire on entry to a match so a stalled H (ce_pix low) cannot refire.
  assign h_line_s     = (H == H_BITS'(LINE_H));
  assign h_scan_s     = (H == H_BITS'(SCAN_H));
  assign line_start_s = h_line_s & ~hpos_line_r;
  assign scan_pt_s    = h_scan_s & ~hpos_scan_r;

  assign vbl_s  = line_start_s & (V == V_BITS'(VBL_LINE));
  assign scan_s = scan_pt_s & shrg_mode & scb_irq & (V < V_BITS'(VBL_LINE));

  video_frame_div #(.DIV(QTR_FRAMES)) u_qtr_div (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .tick    (vbl_s),
    .wrap    (qtr_s)
  );

  video_frame_div #(.DIV(SEC_FRAMES)) u_sec_div (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .tick    (vbl_s),
    .wrap    (sec_s)
  );

  for (genvar k = 0; k < N_CMP; k++) begin : g_cmp
    assign cmp_s[k] = line_start_s & (V == cmp_line[k*V_BITS +: V_BITS]);
  end

  // gather all sources into the status bit order
  always_comb begin
    event_s                   = '0;
    event_s[IRQ_VBL]          = vbl_s;
    event_s[IRQ_QTR]          = qtr_s;
    event_s[IRQ_SEC]          = sec_s;
    event_s[IRQ_SCAN]         = scan_s;
    event_s[IRQ_CMP0 +: N_CMP] = cmp_s;
  end

  // previous-cycle H match flags; start high so nothing fires straight out of reset
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hpos_line_r <= 1'b1;
      hpos_scan_r <= 1'b1;
    end else begin
      hpos_line_r <= h_line_s;
      hpos_scan_r <= h_scan_s;
    end
  end

  // sticky status: a new event outranks a clear in the same cycle
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      status_r <= '0;
    end else begin
      status_r <= (status_r & ~irq_clr) | (event_s & irq_en);
    end
  end

  // legacy pulses and blanking level, independent of the enables
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      vbl_irq_r      <= 1'b0;
      scanline_irq_r <= 1'b0;
      in_vbl_r       <= 1'b0;
    end else begin
      vbl_irq_r      <= vbl_s;
      scanline_irq_r <= scan_s | (|cmp_s);
      in_vbl_r       <= (V >= V_BITS'(VBL_LINE));
    end
  end

  assign irq_status   = status_r;
  assign irq          = |(status_r & irq_en);
  assign vbl_irq      = vbl_irq_r;
  assign scanline_irq = scanline_irq_r;
  assign in_vbl       = in_vbl_r;

endmodule

// File: tb/tb_video_irq_gen.sv
// Scoreboard bench for video_irq_gen: the stimulus side pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_video_irq_gen;
  import video_pkg::*;

  logic        clk_vid = 1'b0;
  logic        reset_n;
  logic [9:0]  H;
  logic [8:0]  V;
  logic        shrg_mode;
  logic        scb_irq;
  logic [17:0] cmp_line;
  irq_vec_t    irq_en;
  irq_vec_t    irq_clr;
  irq_vec_t    irq_status;
  logic        irq;
  logic        vbl_irq;
  logic        scanline_irq;
  logic        in_vbl;

  always #5 clk_vid = ~clk_vid;

  video_irq_gen dut (
    .clk_vid      (clk_vid),
    .reset_n      (reset_n),
    .H            (H),
    .V            (V),
    .shrg_mode    (shrg_mode),
    .scb_irq      (scb_irq),
    .cmp_line     (cmp_line),
    .irq_en       (irq_en),
    .irq_clr      (irq_clr),
    .irq_status   (irq_status),
    .irq          (irq),
    .vbl_irq      (vbl_irq),
    .scanline_irq (scanline_irq),
    .in_vbl       (in_vbl)
  );

  typedef struct {
    logic [5:0] st;
    logic       irq;
    logic       vbl;
    logic       scn;
    logic       invbl;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  // reference model state: total VBLs since reset, H history, latched status
  int         vbl_total;
  bit         prev_line;
  bit         prev_scan;
  logic [5:0] m_st;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
  endtask

  // compute expectation for the coming edge, queue it, advance one cycle
  task automatic step();
    exp_t       e;
    bit         ls, sp, vb;
    logic [5:0] ev;
    if (!reset_n) begin
      vbl_total = 0;
      prev_line = 1'b1;
      prev_scan = 1'b1;
      m_st      = '0;
      e = '{st: 6'd0, irq: 1'b0, vbl: 1'b0, scn: 1'b0, invbl: 1'b0};
    end else begin
      ls = (H == 10'd0) && !prev_line;
      sp = (H == 10'd640) && !prev_scan;
      vb = ls && (V == 9'd400);
      if (vb) vbl_total++;
      ev    = '0;
      ev[0] = vb;
      ev[1] = vb && (vbl_total % 15 == 0);
      ev[2] = vb && (vbl_total % 60 == 0);
      ev[3] = sp && shrg_mode && scb_irq && (V < 9'd400);
      for (int k = 0; k < 2; k++) ev[4+k] = ls && (V == cmp_line[k*9 +: 9]);
      for (int i = 0; i < 6; i++) begin
        if (ev[i] && irq_en[i]) m_st[i] = 1'b1;
        else if (irq_clr[i])    m_st[i] = 1'b0;
      end
      e.st    = m_st;
      e.irq   = |(m_st & irq_en);
      e.vbl   = vb;
      e.scn   = ev[3] | ev[4] | ev[5];
      e.invbl = (V >= 9'd400);
      prev_line = (H == 10'd0);
      prev_scan = (H == 10'd640);
    end
    sb_q.push_back(e);
    @(posedge clk_vid);
    @(negedge clk_vid);
    #1;
    irq_clr = '0;
  endtask

  task automatic do_line(input int v);
    V       = 9'(v);
    scb_irq = (v == 100);
    H = 10'd0;   step();
    H = 10'd1;   step();
    H = 10'd640; step();
    H = 10'd641; step();
  endtask

  task automatic frame();
    do_line(10);  do_line(37);  do_line(100); do_line(399);
    do_line(400); do_line(401); do_line(511);
  endtask

  // monitor: DUT outputs are valid every cycle, compared at the falling edge
  always @(negedge clk_vid) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("irq_status",   32'(irq_status),   32'(mon_e.st));
      check("irq",          32'(irq),          32'(mon_e.irq));
      check("vbl_irq",      32'(vbl_irq),      32'(mon_e.vbl));
      check("scanline_irq", 32'(scanline_irq), 32'(mon_e.scn));
      check("in_vbl",       32'(in_vbl),       32'(mon_e.invbl));
    end
  end

  initial begin
    reset_n   = 1'b0;
    H         = 10'd0;
    V         = 9'd0;
    shrg_mode = 1'b0;
    scb_irq   = 1'b0;
    cmp_line  = {9'd511, 9'd37};
    irq_en    = '0;
    irq_clr   = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // VBL with enable
    irq_en = 6'b000001;
    frame();

    // frame dividers
    irq_clr = 6'b111111;
    H = 10'd5; step();
    irq_en = 6'b000111;
    repeat (60) frame();

    // SCB line interrupt, with and without super hires
    irq_clr = 6'b111111;
    irq_en = 6'b001000;
    shrg_mode = 1'b1;
    frame();
    irq_clr = 6'b111111;
    shrg_mode = 1'b0;
    frame();

    // raster compares, with H stalled on the line start
    irq_en = 6'b110000;
    frame();
    irq_clr = 6'b110000;
    V = 9'd37; H = 10'd700; step();
    H = 10'd0;
    repeat (20) step();

    // clear vs set collision, then clear alone
    irq_en = 6'b000001;
    frame();
    V = 9'd400; H = 10'd5; step();
    H = 10'd0; irq_clr = 6'b000001; step();
    H = 10'd5; irq_clr = 6'b000001; step();
    step();

    // disabled event, masking, then async reset mid-frame
    irq_en = 6'b000000;
    frame();
    irq_en = 6'b000001;
    frame();
    irq_en = 6'b000000;
    step();
    irq_en = 6'b000001;
    V = 9'd450; H = 10'd20; step();
    reset_n = 1'b0;
    #2;
    check("async_rst_status", 32'(irq_status), 32'd0);
    check("async_rst_irq",    32'(irq),        32'd0);
    check("async_rst_pulses", 32'({vbl_irq, scanline_irq}), 32'd0);
    check("async_rst_in_vbl", 32'(in_vbl),     32'd0);
    @(negedge clk_vid); #1;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 3))
        0: H = 10'd0;
        1: H = 10'd640;
        2: H = H;
        default: H = 10'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: V = 9'd400;
        1: V = 9'd37;
        2: V = 9'd100;
        3: V = V;
        default: V = 9'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) cmp_line = {9'($urandom), 9'($urandom_range(0, 1) ? 37 : $urandom)};
      shrg_mode = 1'($urandom);
      scb_irq   = 1'($urandom);
      if ($urandom_range(0, 7) == 0) irq_en = 6'($urandom);
      if ($urandom_range(0, 3) == 0) irq_clr = 6'($urandom);
      step();
    end

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk_vid);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
